// File: rtl/st_pkg.sv
// Shared types, default window constants and the fault check for the stack-region responder.
package st_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StResp
    } st_state_e;

    localparam int unsigned ST_BASE_DEF  = 32'h0000_1000;
    localparam int unsigned ST_LIMIT_DEF = 32'h0000_0C00;

    // Misalignment always faults; the window check can be bypassed by frc.
    function automatic logic fault_check(input logic [31:0] addr, input logic frc,
                                         input logic [31:0] base, input logic [31:0] limit);
        return (addr[1:0] != 2'b00) || (!frc && ((addr < limit) || (addr >= base)));
    endfunction

endpackage

// File: rtl/st_stack_mem_if.sv
// Request/response bus between the stack top (master) and the stack memory (slave).
interface st_stack_mem_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_force;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_force, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_force, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/st_stack_ram.sv
// Single-port synchronous stack RAM with registered read data; contents are never reset.
module st_stack_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // One access per cycle: a write takes the port, otherwise a read registers the word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/st_stack_mem.sv
// Stack-region data-memory responder: writes go straight to RAM, reads and faults produce a
// held response. Optional watermark output enabled by macro ST_WATERMARK_EN.
module st_stack_mem
    import st_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STACK_BASE  = ST_BASE_DEF,
    parameter int unsigned STACK_LIMIT = ST_LIMIT_DEF,
    parameter int unsigned DEPTH       = 256
) (
    input  logic          clk,
    input  logic          reset,
    st_stack_mem_if.slave bus,
    output logic [7:0]    fault_cnt
`ifdef ST_WATERMARK_EN
    ,
    output logic [ADDR_W-1:0] hwm
`endif
);
    localparam int unsigned IdxW = $clog2(DEPTH);

    st_state_e         state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_fault_q;
    logic [7:0]        fault_cnt_q;

    logic              accept;
    logic              req_fault;
    logic [IdxW-1:0]   ram_idx;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    // Request decode; ready is only high in idle, so accept implies idle.
    always_comb begin
        accept    = bus.req_valid && req_ready_q;
        req_fault = fault_check(32'(bus.req_addr), bus.req_force, STACK_BASE, STACK_LIMIT);
        // Forced out-of-window addresses wrap modulo DEPTH through this truncation.
        ram_idx   = IdxW'((bus.req_addr - ADDR_W'(STACK_LIMIT)) >> 2);
        ram_we    = accept && bus.req_wr && !req_fault;
        ram_re    = accept && !bus.req_wr && !req_fault;
    end

    st_stack_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_idx),
        .wdata_i (bus.req_wdata),
        .rdata_o (ram_rdata)
    );

    // Control FSM with registered handshake, response and fault-count outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            fault_cnt_q <= 8'h00;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (req_fault) begin
                            state_q     <= StResp;
                            req_ready_q <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_fault_q <= 1'b1;
                            if (fault_cnt_q != 8'hFF) begin
                                fault_cnt_q <= fault_cnt_q + 8'd1;
                            end
                        end else if (!bus.req_wr) begin
                            state_q     <= StRdWait;
                            req_ready_q <= 1'b0;
                        end
                    end
                end
                StRdWait: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= ram_rdata;
                    rsp_fault_q <= 1'b0;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ST_WATERMARK_EN
    logic [ADDR_W-1:0] hwm_q;

    // Track the deepest in-window pushed address.
    always_ff @(posedge clk) begin
        if (reset) begin
            hwm_q <= ADDR_W'(STACK_BASE);
        end else if (ram_we && !fault_check(32'(bus.req_addr), 1'b0, STACK_BASE, STACK_LIMIT)
                     && (bus.req_addr < hwm_q)) begin
            hwm_q <= bus.req_addr;
        end
    end

    assign hwm = hwm_q;
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign fault_cnt     = fault_cnt_q;
endmodule

// File: tb/tb_st_stack_mem.sv
// Directed, table-driven bench for st_stack_mem.
module tb_st_stack_mem;
    logic       clk;
    logic       reset;
    logic [7:0] fault_cnt;
`ifdef ST_WATERMARK_EN
    logic [15:0] hwm;
`endif

    int checks;
    int errors;
    int model_cnt;

    st_stack_mem_if bus ();

    st_stack_mem dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fault_cnt (fault_cnt)
`ifdef ST_WATERMARK_EN
        ,
        .hwm       (hwm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        frc;
        logic        exp_fault;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction with rsp_ready held high; checks latency, data, fault and counter.
    task automatic do_req(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic frc, input logic exp_fault, input logic [31:0] exp_rdata,
                          input string name);
        int lat;
        int exp_lat;
        bit seen;
        exp_lat = exp_fault ? 1 : (wr ? 0 : 2);
        @(negedge clk);
        chk({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_force = frc;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        seen = 0;
        lat  = 0;
        for (int k = 1; k <= 4 && !seen; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1;
                lat  = k;
            end
        end
        if (exp_fault) model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        if (seen) begin
            chk({name, " rsp_fault"}, 32'(bus.rsp_fault), 32'(exp_fault));
            chk({name, " rsp_rdata"}, bus.rsp_rdata, exp_rdata);
            @(negedge clk);
            chk({name, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
            chk({name, " req_ready back"}, 32'(bus.req_ready), 32'd1);
        end
        chk({name, " fault_cnt"}, 32'(fault_cnt), 32'(model_cnt));
    endtask

    initial begin
        bit seen;
        logic [31:0] held;
        checks        = 0;
        errors        = 0;
        model_cnt     = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_force = 1'b0;
        bus.rsp_ready = 1'b1;

        vecs[0]  = '{1'b1, 16'h0FFC, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 16'h0FFC, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 16'h1000, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 16'h0FFC, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 16'h1000, 32'h12345678, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 16'h0C00, 32'h0,        1'b0, 1'b0, 32'h12345678};
        vecs[6]  = '{1'b0, 16'h0C02, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 16'h0BFC, 32'h00000001, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 16'h0BFC, 32'hAAAA5555, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 16'h0FFC, 32'h0,        1'b0, 1'b0, 32'hAAAA5555};
        vecs[10] = '{1'b1, 16'h0FF8, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 16'h0FF8, 32'h0,        1'b0, 1'b0, 32'h5A5A5A5A};
        vecs[12] = '{1'b0, 16'h0FFD, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 16'h0C00, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 16'h0C00, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D};
        vecs[15] = '{1'b1, 16'h0800, 32'h00000099, 1'b0, 1'b1, 32'h0};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("reset rsp_fault", 32'(bus.rsp_fault), 32'd0);
        chk("reset fault_cnt", 32'(fault_cnt), 32'd0);
`ifdef ST_WATERMARK_EN
        chk("reset hwm", 32'(hwm), 32'h1000);
`endif

        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].frc, vecs[i].exp_fault,
                   vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end

        // Back-to-back writes on consecutive edges.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_force = 1'b0;
        bus.req_addr  = 16'h0C10;
        bus.req_wdata = 32'h01010101;
        @(posedge clk);
        #1;
        bus.req_addr  = 16'h0C14;
        bus.req_wdata = 32'h02020202;
        @(negedge clk);
        chk("b2b req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        do_req(1'b0, 16'h0C10, 32'h0, 1'b0, 1'b0, 32'h01010101, "b2b rd0");
        do_req(1'b0, 16'h0C14, 32'h0, 1'b0, 1'b0, 32'h02020202, "b2b rd1");

        // Backpressure: response must hold while rsp_ready is low.
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 16'h0C00;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
        end
        chk("bp rsp_valid seen", 32'(seen), 32'd1);
        held = bus.rsp_rdata;
        chk("bp rdata", held, 32'hCAFEF00D);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            chk($sformatf("bp hold valid %0d", k), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp hold rdata %0d", k), bus.rsp_rdata, 32'hCAFEF00D);
            chk($sformatf("bp req_ready %0d", k), 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp after req_ready", 32'(bus.req_ready), 32'd1);
        chk("bp after rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Reset while in RD_WAIT.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 16'h0FFC;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset         = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk("rst mid rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst mid req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst mid fault_cnt", 32'(fault_cnt), 32'd0);
        @(negedge clk);
        chk("rst mid no late valid", 32'(bus.rsp_valid), 32'd0);
`ifdef ST_WATERMARK_EN
        chk("rst mid hwm", 32'(hwm), 32'h1000);
`endif
        do_req(1'b0, 16'h0FFC, 32'h0, 1'b0, 1'b0, 32'hAAAA5555, "rst ram kept");

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            do_req(1'b0, 16'h1000, 32'h0, 1'b0, 1'b1, 32'h0, "sat");
        end
        chk("sat fault_cnt", 32'(fault_cnt), 32'h000000FF);

`ifdef ST_WATERMARK_EN
        do_req(1'b1, 16'h0FF0, 32'h1, 1'b0, 1'b0, 32'h0, "wm w0");
        do_req(1'b1, 16'h0FF8, 32'h2, 1'b0, 1'b0, 32'h0, "wm w1");
        chk("wm hwm", 32'(hwm), 32'h0FF0);
        do_req(1'b1, 16'h0BFC, 32'h3, 1'b1, 1'b0, 32'h0, "wm forced");
        chk("wm hwm forced", 32'(hwm), 32'h0FF0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
